// File: rtl/imm_ext_pipe_pkg.sv
// ext_pkg: shared types and default widths for the immediate-extension stage.
//   ext_mode_t : extension mode carried with each immediate
//   IMM_W      : default raw immediate width
//   WORD_W     : default extended operand width
package ext_pkg;
  typedef enum logic [1:0] {
    EXT_SIGN   = 2'd0,
    EXT_ZERO   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRANCH = 2'd3
  } ext_mode_t;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;
endpackage

// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: handshake bundle around the immediate-extension stage.
//   Input side  : in_valid/in_ready, in_imm, in_mode, in_tag, flush
//   Output side : out_valid/out_ready, out_imm, out_tag
//   master = producer/consumer environment, slave = the stage itself.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  import ext_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  ext_mode_t        in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_ext_pipe_core.sv
// ext_core: purely combinational immediate extender.
//   imm  [IN_W]  : raw immediate
//   mode [2]     : ext_mode_t
//   ext  [OUT_W] : extended value (sign / zero / upper / branch offset)
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] ext
);
  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  assign sext = {{E{imm[IN_W-1]}}, imm};

  always_comb begin
    ext = sext;
    unique case (mode)
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = {{E{1'b0}}, imm};
      EXT_UPPER:  ext = {imm, {E{1'b0}}};
      // Word offset -> byte offset; top two sign bits fall off.
      EXT_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:    ext = sext;
    endcase
  end
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage with a 2-entry skid buffer.
//   clk, rst_n : clock, async active-low reset
//   bus        : imm_ext_pipe_if.slave (input handshake + flush, output handshake)
// Extension happens before storage, so only OUT_W data + tag are registered.
// in_ready is the inverse of the skid valid bit, so it never depends on
// out_ready combinationally.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_pipe_if.slave bus
);
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be >= IN_W+2");
  end

  logic [OUT_W-1:0] ext;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (bus.in_imm),
    .mode (bus.in_mode),
    .ext  (ext)
  );

  logic             main_v, skid_v;
  logic [OUT_W-1:0] main_d, skid_d;
  logic [TAG_W-1:0] main_t, skid_t;
  logic             acc, drain;

  // An input offered alongside flush is dropped.
  assign acc   = bus.in_valid && !skid_v && !bus.flush;
  assign drain = main_v && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
      main_t <= '0;
      skid_t <= '0;
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain || !main_v) begin
      // Main is free this edge: oldest item (skid first) moves in.
      if (skid_v) begin
        main_v <= 1'b1;
        main_d <= skid_d;
        main_t <= skid_t;
        skid_v <= 1'b0;
      end else if (acc) begin
        main_v <= 1'b1;
        main_d <= ext;
        main_t <= bus.in_tag;
      end else begin
        main_v <= 1'b0;
      end
    end else if (acc) begin
      // Main stalled: park the new item in skid, which drops in_ready.
      skid_v <= 1'b1;
      skid_d <= ext;
      skid_t <= bus.in_tag;
    end
  end

  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_imm   = main_d;
  assign bus.out_tag   = main_t;
endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;
  import ext_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) b1 ();
  imm_ext_pipe_if #(.IN_W(12), .OUT_W(20), .TAG_W(5)) b2 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  imm_ext_pipe #(.IN_W(12), .OUT_W(20), .TAG_W(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] imm, input ext_mode_t m, input logic [4:0] t);
    b1.in_valid = v;
    b1.in_imm   = imm;
    b1.in_mode  = m;
    b1.in_tag   = t;
  endtask

  // Reference for IN_W=12, OUT_W=20 using integer arithmetic.
  function automatic logic [19:0] ref12(input logic [11:0] imm, input logic [1:0] m);
    int s;
    int u;
    u = int'(imm);
    s = imm[11] ? u - 4096 : u;
    case (m)
      2'd0:    return 20'(s);
      2'd1:    return 20'(u);
      2'd2:    return 20'(u * 256);
      default: return 20'(s * 4);
    endcase
  endfunction

  initial begin
    put(1'b0, 16'h0, EXT_SIGN, 5'd0);
    b1.flush = 1'b0;
    b1.out_ready = 1'b0;
    b2.in_valid = 1'b0;
    b2.in_imm = '0;
    b2.in_mode = EXT_SIGN;
    b2.in_tag = '0;
    b2.flush = 1'b0;
    b2.out_ready = 1'b1;

    // Reset with clock running
    repeat (3) step();
    chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
    chk("rst_in_ready",  32'(b1.in_ready),  32'd1);
    chk("rst_out_imm",   b1.out_imm,        32'h0);
    chk("rst_out_tag",   32'(b1.out_tag),   32'd0);
    rst_n = 1'b1;

    // Modes, back-to-back with out_ready=1
    b1.out_ready = 1'b1;
    put(1'b1, 16'h8001, EXT_SIGN, 5'd1);   step();
    chk("sign_valid", 32'(b1.out_valid), 32'd1);
    chk("sign",   b1.out_imm, 32'hFFFF8001);
    put(1'b1, 16'h8001, EXT_ZERO, 5'd2);   step();
    chk("zero",   b1.out_imm, 32'h00008001);
    chk("zero_tag", 32'(b1.out_tag), 32'd2);
    put(1'b1, 16'h8001, EXT_UPPER, 5'd3);  step();
    chk("upper",  b1.out_imm, 32'h80010000);
    put(1'b1, 16'h8001, EXT_BRANCH, 5'd4); step();
    chk("branch", b1.out_imm, 32'hFFFE0004);
    put(1'b1, 16'h7FFF, EXT_SIGN, 5'd5);   step();
    chk("sign_pos", b1.out_imm, 32'h00007FFF);
    put(1'b0, 16'h0, EXT_SIGN, 5'd0);      step();
    chk("idle_valid", 32'(b1.out_valid), 32'd0);

    // Backpressure: only two accepted
    b1.out_ready = 1'b0;
    put(1'b1, 16'h0011, EXT_ZERO, 5'd1); step();
    chk("bp_rdy1", 32'(b1.in_ready), 32'd1);
    put(1'b1, 16'h0022, EXT_ZERO, 5'd2); step();
    chk("bp_rdy2", 32'(b1.in_ready), 32'd0);
    put(1'b1, 16'h0033, EXT_ZERO, 5'd3); step();
    chk("bp_hold_tag", 32'(b1.out_tag), 32'd1);
    chk("bp_hold_imm", b1.out_imm, 32'h00000011);
    chk("bp_rdy3", 32'(b1.in_ready), 32'd0);
    b1.out_ready = 1'b1; step();
    chk("bp_out2", 32'(b1.out_tag), 32'd2);
    chk("bp_rdy4", 32'(b1.in_ready), 32'd1);
    step();
    chk("bp_out3", 32'(b1.out_tag), 32'd3);
    chk("bp_out3_imm", b1.out_imm, 32'h00000033);
    put(1'b0, 16'h0, EXT_SIGN, 5'd0); step();
    chk("bp_empty", 32'(b1.out_valid), 32'd0);

    // Flush with one entry held and in_ready=1: input dropped
    b1.out_ready = 1'b0;
    put(1'b1, 16'h0001, EXT_ZERO, 5'd6); step();
    put(1'b1, 16'h0007, EXT_ZERO, 5'd7); b1.flush = 1'b1; step();
    b1.flush = 1'b0; put(1'b0, 16'h0, EXT_SIGN, 5'd0);
    chk("fl1_valid", 32'(b1.out_valid), 32'd0);
    chk("fl1_rdy", 32'(b1.in_ready), 32'd1);

    // Flush with two entries held
    put(1'b1, 16'h0004, EXT_ZERO, 5'd4); step();
    put(1'b1, 16'h0005, EXT_ZERO, 5'd5); step();
    chk("fl2_full", 32'(b1.in_ready), 32'd0);
    put(1'b1, 16'h0007, EXT_ZERO, 5'd7); b1.flush = 1'b1; step();
    b1.flush = 1'b0; put(1'b0, 16'h0, EXT_SIGN, 5'd0);
    chk("fl2_valid", 32'(b1.out_valid), 32'd0);
    chk("fl2_rdy", 32'(b1.in_ready), 32'd1);
    b1.out_ready = 1'b1; step();
    chk("fl2_no_tag7", 32'(b1.out_valid), 32'd0);

    // Async reset between edges
    b1.out_ready = 1'b0;
    put(1'b1, 16'h0009, EXT_ZERO, 5'd9); step();
    put(1'b0, 16'h0, EXT_SIGN, 5'd0);
    chk("ar_pre_valid", 32'(b1.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(b1.out_valid), 32'd0);
    chk("ar_imm", b1.out_imm, 32'h0);
    chk("ar_rdy", 32'(b1.in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    b1.out_ready = 1'b1;
    put(1'b1, 16'h0005, EXT_ZERO, 5'd10); step();
    put(1'b0, 16'h0, EXT_SIGN, 5'd0);
    chk("ar_new_valid", 32'(b1.out_valid), 32'd1);
    chk("ar_new_tag", 32'(b1.out_tag), 32'd10);
    chk("ar_new_imm", b1.out_imm, 32'h00000005);

    // Streaming on the 12->20 instance
    for (int i = 0; i < 8; i++) begin
      logic [11:0] imm;
      logic [1:0]  m;
      logic [19:0] exp;
      imm = 12'($urandom_range(0, 4095));
      m   = 2'($urandom_range(0, 3));
      exp = ref12(imm, m);
      b2.in_valid = 1'b1;
      b2.in_imm   = imm;
      b2.in_mode  = ext_mode_t'(m);
      b2.in_tag   = 5'(i);
      step();
      chk("st_valid", 32'(b2.out_valid), 32'd1);
      chk("st_tag", 32'(b2.out_tag), 32'(i));
      chk("st_imm", 32'(b2.out_imm), 32'(exp));
    end
    b2.in_valid = 1'b0;
    step();
    chk("st_end", 32'(b2.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
